// File: rtl/rgb_seq_pkg.sv
// rgb_seq_pkg: shared types and constants for the RGB LED mode sequencer.
//   mode_t        - user-visible colour mode (3-bit, codes 6/7 illegal)
//   fade_phase_t  - which channel pair is cross-fading in FADE mode
//   RGB_R/G/B     - bit positions inside the 3-bit channel vector
//   static_colour - solid channel pattern for each mode (FADE has none)
//   next_mode     - mode reached on a button press
package rgb_seq_pkg;

  typedef enum logic [2:0] {
    MODE_OFF   = 3'd0,
    MODE_RED   = 3'd1,
    MODE_GREEN = 3'd2,
    MODE_BLUE  = 3'd3,
    MODE_WHITE = 3'd4,
    MODE_FADE  = 3'd5
  } mode_t;

  typedef enum logic [1:0] {
    PH_P0 = 2'd0,   // red falling, green rising
    PH_P1 = 2'd1,   // green falling, blue rising
    PH_P2 = 2'd2    // blue falling, red rising
  } fade_phase_t;

  localparam int RGB_R = 0;
  localparam int RGB_G = 1;
  localparam int RGB_B = 2;

  localparam logic [2:0] COL_OFF   = 3'b000;
  localparam logic [2:0] COL_RED   = 3'b001;
  localparam logic [2:0] COL_GREEN = 3'b010;
  localparam logic [2:0] COL_BLUE  = 3'b100;
  localparam logic [2:0] COL_WHITE = 3'b111;

  function automatic logic [2:0] static_colour(mode_t m);
    case (m)
      MODE_RED:   return COL_RED;
      MODE_GREEN: return COL_GREEN;
      MODE_BLUE:  return COL_BLUE;
      MODE_WHITE: return COL_WHITE;
      default:    return COL_OFF;
    endcase
  endfunction

  function automatic mode_t next_mode(mode_t m);
    case (m)
      MODE_OFF:   return MODE_RED;
      MODE_RED:   return MODE_GREEN;
      MODE_GREEN: return MODE_BLUE;
      MODE_BLUE:  return MODE_WHITE;
      MODE_WHITE: return MODE_FADE;
      default:    return MODE_OFF;
    endcase
  endfunction

endpackage

// File: rtl/rgb_mode_sequencer_if.sv
// rgb_mode_sequencer_if: button input and LED/status outputs of the sequencer.
//   step        - debounced button level, active-high (master -> slave)
//   rgb_on      - channel drive, active-high, bit0=R bit1=G bit2=B
//   mode        - current colour mode
//   fade_active - high while mode is FADE
// master: the debouncer/top-level side; slave: the sequencer.
interface rgb_mode_sequencer_if;
  import rgb_seq_pkg::*;

  logic       step;
  logic [2:0] rgb_on;
  mode_t      mode;
  logic       fade_active;

  modport master (output step, input rgb_on, input mode, input fade_active);
  modport slave  (input step, output rgb_on, output mode, output fade_active);
endinterface

// File: rtl/rgb_mode_sequencer_pwm_compare.sv
// pwm_compare: shared PWM timebase plus three registered duty comparators.
//   clk, rst        - system clock, synchronous active-high reset
//   enable_i        - run the timebase; when low, counters and outputs clear to 0
//   duty_r/g/b_i    - per-channel duty, channel on while pwm_cnt < duty
//   on_o            - registered channel-on vector (bit order from RGB_R/G/B)
module pwm_compare
  import rgb_seq_pkg::*;
#(
  parameter int PWM_WIDTH    = 8,
  parameter int PWM_PRESCALE = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_i,
  input  logic [PWM_WIDTH-1:0] duty_r_i,
  input  logic [PWM_WIDTH-1:0] duty_g_i,
  input  logic [PWM_WIDTH-1:0] duty_b_i,
  output logic [2:0]           on_o
);

  localparam int PS_W = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;

  logic [PS_W-1:0]      prescale_cnt_q;
  logic [PWM_WIDTH-1:0] pwm_cnt_q;
  logic [2:0]           on_q;
  logic                 ps_tc;

  assign ps_tc = (prescale_cnt_q == PS_W'(PWM_PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (rst || !enable_i) begin
      prescale_cnt_q <= '0;
      pwm_cnt_q      <= '0;
      on_q           <= '0;
    end else begin
      on_q[RGB_R] <= (pwm_cnt_q < duty_r_i);
      on_q[RGB_G] <= (pwm_cnt_q < duty_g_i);
      on_q[RGB_B] <= (pwm_cnt_q < duty_b_i);
      if (ps_tc) begin
        prescale_cnt_q <= '0;
        pwm_cnt_q      <= pwm_cnt_q + 1'b1;   // wraps mod 2^W
      end else begin
        prescale_cnt_q <= prescale_cnt_q + 1'b1;
      end
    end
  end

  assign on_o = on_q;

endmodule

// File: rtl/rgb_mode_sequencer.sv
// rgb_mode_sequencer: steps the board RGB LED through
// OFF -> RED -> GREEN -> BLUE -> WHITE -> FADE -> OFF on each button press.
// Static modes drive solid channels; FADE cross-fades channel pairs around a
// hue wheel and PWM-modulates the result through pwm_compare.
//   clk, rst - system clock, synchronous active-high reset
//   bus      - rgb_mode_sequencer_if.slave (step in; rgb_on, mode, fade_active out)
// Optional build macro RGB_SEQ_LONG_PRESS_EN: holding the button for
// LONG_PRESS_TICKS cycles forces OFF once per hold.
//
// mode       | meaning
// MODE_OFF   | all channels off
// MODE_RED   | red solid
// MODE_GREEN | green solid
// MODE_BLUE  | blue solid
// MODE_WHITE | all channels solid
// MODE_FADE  | hue-wheel fade with PWM output
// 6, 7       | illegal, recover to OFF next clock
module rgb_mode_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int PWM_WIDTH        = 8,
  parameter int PWM_PRESCALE     = 5,
  parameter int FADE_STEP_TICKS  = 120_000,
  parameter int LONG_PRESS_TICKS = 12_000_000
) (
  input logic                 clk,
  input logic                 rst,
  rgb_mode_sequencer_if.slave bus
);

  localparam int FC_W = (FADE_STEP_TICKS > 1) ? $clog2(FADE_STEP_TICKS) : 1;
  localparam logic [PWM_WIDTH-1:0] DUTY_MAX  = {PWM_WIDTH{1'b1}};
  localparam logic [PWM_WIDTH-1:0] DUTY_LAST = DUTY_MAX - 1'b1;

  if (PWM_WIDTH < 1 || PWM_PRESCALE < 1 || FADE_STEP_TICKS < 1 || LONG_PRESS_TICKS < 1)
  begin : g_param_check
    $error("rgb_mode_sequencer: all parameters must be >= 1");
  end

  mode_t                mode_q, mode_d;
  fade_phase_t          phase_q, phase_d;
  logic                 step_prev_q;
  logic [2:0]           static_q;
  logic [PWM_WIDTH-1:0] duty_r_q, duty_r_d;
  logic [PWM_WIDTH-1:0] duty_g_q, duty_g_d;
  logic [PWM_WIDTH-1:0] duty_b_q, duty_b_d;
  logic [FC_W-1:0]      fade_cnt_q, fade_cnt_d;
  logic                 press;
  logic                 long_hit;
  logic                 fade_now, fade_next;
  logic [2:0]           pwm_on;

  assign press = bus.step & ~step_prev_q;

`ifdef RGB_SEQ_LONG_PRESS_EN
  localparam int HOLD_W = $clog2(LONG_PRESS_TICKS + 1);
  logic [HOLD_W-1:0] hold_q;

  // Saturating at LONG_PRESS_TICKS (one past the hit value) makes the hit a
  // single event per hold.
  always_ff @(posedge clk) begin
    if (rst || !bus.step) begin
      hold_q <= '0;
    end else if (hold_q != HOLD_W'(LONG_PRESS_TICKS)) begin
      hold_q <= hold_q + 1'b1;
    end
  end

  assign long_hit = bus.step && (hold_q == HOLD_W'(LONG_PRESS_TICKS - 1));
`else
  assign long_hit = 1'b0;
`endif

  always_comb begin
    mode_d = mode_q;
    if (press) begin
      mode_d = next_mode(mode_q);
    end else if (mode_q > MODE_FADE) begin
      mode_d = MODE_OFF;
    end
    if (long_hit) begin
      mode_d = MODE_OFF;
    end
  end

  assign fade_now  = (mode_q == MODE_FADE);
  assign fade_next = (mode_d == MODE_FADE);

  // Fade sequencer. A mode change takes priority: any step due on the same
  // edge is dropped, and duties are left frozen while outside FADE.
  always_comb begin
    duty_r_d   = duty_r_q;
    duty_g_d   = duty_g_q;
    duty_b_d   = duty_b_q;
    phase_d    = phase_q;
    fade_cnt_d = '0;
    if (fade_next && !fade_now) begin
      duty_r_d = DUTY_MAX;
      duty_g_d = '0;
      duty_b_d = '0;
      phase_d  = PH_P0;
    end else if (fade_next && fade_now) begin
      if (fade_cnt_q == FC_W'(FADE_STEP_TICKS - 1)) begin
        case (phase_q)
          PH_P0: begin
            duty_r_d = duty_r_q - 1'b1;
            duty_g_d = duty_g_q + 1'b1;
            if (duty_g_q == DUTY_LAST) phase_d = PH_P1;
          end
          PH_P1: begin
            duty_g_d = duty_g_q - 1'b1;
            duty_b_d = duty_b_q + 1'b1;
            if (duty_b_q == DUTY_LAST) phase_d = PH_P2;
          end
          PH_P2: begin
            duty_b_d = duty_b_q - 1'b1;
            duty_r_d = duty_r_q + 1'b1;
            if (duty_r_q == DUTY_LAST) phase_d = PH_P0;
          end
          default: phase_d = PH_P0;
        endcase
      end else begin
        fade_cnt_d = fade_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= MODE_OFF;
      phase_q     <= PH_P0;
      step_prev_q <= 1'b1;   // a button held through reset is not a press
      static_q    <= COL_OFF;
      duty_r_q    <= '0;
      duty_g_q    <= '0;
      duty_b_q    <= '0;
      fade_cnt_q  <= '0;
    end else begin
      mode_q      <= mode_d;
      phase_q     <= phase_d;
      step_prev_q <= bus.step;
      static_q    <= static_colour(mode_q);
      duty_r_q    <= duty_r_d;
      duty_g_q    <= duty_g_d;
      duty_b_q    <= duty_b_d;
      fade_cnt_q  <= fade_cnt_d;
    end
  end

  // Timebase runs only while staying in FADE, so it starts from zero on entry
  // and is already zero the cycle after leaving.
  pwm_compare #(
    .PWM_WIDTH   (PWM_WIDTH),
    .PWM_PRESCALE(PWM_PRESCALE)
  ) u_pwm (
    .clk     (clk),
    .rst     (rst),
    .enable_i(fade_now && fade_next),
    .duty_r_i(duty_r_q),
    .duty_g_i(duty_g_q),
    .duty_b_i(duty_b_q),
    .on_o    (pwm_on)
  );

  assign bus.mode        = mode_q;
  assign bus.fade_active = fade_now;
  assign bus.rgb_on      = fade_now ? pwm_on : static_q;

endmodule

// File: tb/tb_rgb_mode_sequencer.sv
module tb_rgb_mode_sequencer;
  import rgb_seq_pkg::*;

  localparam int W    = 4;
  localparam int P    = 1;
  localparam int F    = 4;
  localparam int L    = 20;
  localparam int DMAX = 15;
  localparam int NSTEPS_PHASE = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rgb_mode_sequencer_if ifc();

  rgb_mode_sequencer #(
    .PWM_WIDTH       (W),
    .PWM_PRESCALE    (P),
    .FADE_STEP_TICKS (F),
    .LONG_PRESS_TICKS(L)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: mode as a number, FADE output derived from time since entry.
  int         m_mode = 0;
  int         m_prev = 1;
  int         m_n    = 0;
  int         m_hold = 0;
  logic [2:0] m_static = 3'b000;
  logic [2:0] m_pwm    = 3'b000;

  function automatic logic [2:0] colour_of(int m);
    case (m)
      1: return 3'b001;
      2: return 3'b010;
      3: return 3'b100;
      4: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  // Output after the n-th edge spent in FADE: PWM count and duties are the
  // values present before that edge.
  function automatic logic [2:0] fade_rgb(int n);
    int pc, k, ph, j, dr, dg, db;
    pc = ((n - 1) / P) % (DMAX + 1);
    k  = (n - 1) / F;
    ph = (k / NSTEPS_PHASE) % 3;
    j  = k % NSTEPS_PHASE;
    dr = 0; dg = 0; db = 0;
    if (ph == 0) begin dr = DMAX - j; dg = j; end
    else if (ph == 1) begin dg = DMAX - j; db = j; end
    else begin db = DMAX - j; dr = j; end
    return {pc < db, pc < dg, pc < dr};
  endfunction

  task automatic model_step();
    int nm;
    if (rst) begin
      m_mode = 0; m_prev = 1; m_n = 0; m_hold = 0;
      m_static = 3'b000; m_pwm = 3'b000;
    end else begin
      nm = m_mode;
      if (ifc.step == 1'b1 && m_prev == 0) nm = (m_mode + 1) % 6;
`ifdef RGB_SEQ_LONG_PRESS_EN
      if (ifc.step == 1'b1) begin
        if (m_hold == L - 1) nm = 0;
        if (m_hold < L) m_hold++;
      end else begin
        m_hold = 0;
      end
`endif
      m_static = colour_of(m_mode);
      if (nm == 5 && m_mode == 5) begin
        m_n++;
        m_pwm = fade_rgb(m_n);
      end else begin
        m_n   = 0;
        m_pwm = 3'b000;
      end
      m_mode = nm;
      m_prev = (ifc.step == 1'b1) ? 1 : 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_eq("mode", ifc.mode, m_mode);
    check_eq("rgb_on", ifc.rgb_on, (m_mode == 5) ? m_pwm : m_static);
    check_eq("fade_active", ifc.fade_active, (m_mode == 5) ? 1 : 0);
  endtask

  task automatic press_once(input int gap);
    ifc.step = 1'b1;
    tick();
    ifc.step = 1'b0;
    repeat (gap) tick();
  endtask

  // Counts channel-on cycles over the first PWM period after FADE entry.
  // Duties step every 4 cycles: R = 15,14,13,12 against counts 0..15 gives
  // 4+4+4+0 = 12 on-slots; G = 0,1,2,3 is never above the count; B stays 0.
  task automatic check_entry_window(input string tag);
    int cr, cg, cb, cr4;
    cr = 0; cg = 0; cb = 0; cr4 = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      cr += int'(ifc.rgb_on[0]);
      cg += int'(ifc.rgb_on[1]);
      cb += int'(ifc.rgb_on[2]);
      if (i == 4) cr4 = cr;
    end
    check_eq({tag, "_r_first4"}, cr4, 4);
    check_eq({tag, "_r_window"}, cr, 12);
    check_eq({tag, "_g_window"}, cg, 0);
    check_eq({tag, "_b_window"}, cb, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.step = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (10) tick();
    check_eq("held_through_reset_mode", ifc.mode, 0);
    check_eq("held_through_reset_rgb", ifc.rgb_on, 0);
    ifc.step = 1'b0;
    tick();

    for (int i = 1; i <= 5; i++) begin
      ifc.step = 1'b1;
      tick();
      check_eq("press_mode", ifc.mode, i);
      ifc.step = 1'b0;
      if (i < 5) begin
        tick();
        check_eq("static_rgb", ifc.rgb_on, colour_of(i));
        repeat (3) tick();
      end
    end
    check_entry_window("fade1");
    repeat (50) tick();

    while ((m_n + 1) % F != 0) tick();
    ifc.step = 1'b1;
    tick();
    check_eq("press_on_fade_step_mode", ifc.mode, 0);
    ifc.step = 1'b0;
    tick();
    check_eq("leave_fade_rgb", ifc.rgb_on, 0);

    for (int i = 0; i < 5; i++) press_once((i == 4) ? 0 : 2);
    check_eq("reenter_mode", ifc.mode, 5);
    check_entry_window("fade2");

    repeat (110) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rst_mid_fade_mode", ifc.mode, 0);
    check_eq("rst_mid_fade_rgb", ifc.rgb_on, 0);
    check_eq("rst_mid_fade_active", ifc.fade_active, 0);
    tick();

    for (int i = 0; i < 5; i++) press_once((i == 4) ? 0 : 2);
    check_entry_window("fade3");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    press_once(3);
    press_once(3);
    check_eq("pre_hold_mode", ifc.mode, 2);
    ifc.step = 1'b1;
    tick();
    check_eq("hold_first_edge_mode", ifc.mode, 3);
    repeat (19) tick();
`ifdef RGB_SEQ_LONG_PRESS_EN
    check_eq("hold_20_mode", ifc.mode, 0);
`else
    check_eq("hold_20_mode", ifc.mode, 3);
`endif
    repeat (5) tick();
    ifc.step = 1'b0;
    repeat (3) tick();
`ifdef RGB_SEQ_LONG_PRESS_EN
    check_eq("after_release_mode", ifc.mode, 0);
`else
    check_eq("after_release_mode", ifc.mode, 3);
`endif

    for (int r = 0; r < 120; r++) begin
      int len;
      len = $urandom_range(1, 30);
      ifc.step = ($urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
      if ($urandom_range(0, 40) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      repeat (len) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
